// File: rtl/fifo_stream_reader_pkg.sv
// Shared FIFO type package: default widths and the data word type used by
// the synchronous FIFO and by its stream reader.
package fifo_stream_reader_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bus bundle for the stream reader: the FIFO read port on one side and the
// valid/ready output stream on the other. The master view belongs to the
// reader; the slave view belongs to the FIFO plus downstream consumer.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
);

    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry first-in first-out register buffer. Head is always presented on
// dout; flush empties it and wins over push and pop.
module fifo_out_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign dout   = head;
    assign occ    = count;

    // Entry and occupancy update; simultaneous push and pop keeps the count
    // and shifts the tail forward so ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= din;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= din;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain stage for the synchronous FIFO: issues reads, absorbs the one-cycle
// read latency into a 2-entry buffer and presents a valid/ready stream.
// Also counts completed handshakes and latches any underflowing read.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 flush,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic                 underflow_err
);

    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [2:0]            budget;
    logic [FIFO_WIDTH-1:0] buf_dout;

    // Read issue: only read when the word in flight plus what stays buffered
    // after this cycle's pop leaves room, so the buffer can never overfill.
    // Gated by rst_n so the read port is quiet while reset is held.
    always_comb begin
        pop    = (occ != 2'd0) && bus.m_ready;
        push   = inflight && !bus.fifo_underflow && !flush;
        budget = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        rd_en  = rst_n && enable && !flush && !bus.fifo_empty && (budget <= 3'd1);
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = buf_dout;

    // In-flight flag mirrors last cycle's read; a flush drops the pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= flush ? 1'b0 : rd_en;
        end
    end

    // Handshake counter, wraps naturally; a pop that coincides with flush is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (pop && !flush) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

    // Sticky error when a returning read is flagged as underflow; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else if (inflight && bus.fifo_underflow) begin
            underflow_err <= 1'b1;
        end
    end

    fifo_out_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (bus.fifo_data_out),
        .dout  (buf_dout),
        .occ   (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader with a behavioural FIFO model
// on the read port and a scoreboard on the output stream.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] xfer_count;
    logic        underflow_err;

    fifo_stream_reader_if #(.FIFO_WIDTH(16)) bus();

    fifo_stream_reader #(
        .FIFO_WIDTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .flush         (flush),
        .bus           (bus),
        .xfer_count    (xfer_count),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    fifo_word_t fifo_q[$];
    fifo_word_t exp_q[$];
    int         pushed = 0;
    int         popped = 0;
    int         words_sent = 0;
    logic       force_uf = 1'b0;
    int         occ_bad = 0;

    logic       prev_valid = 1'b0;
    logic       prev_pop = 1'b0;
    logic       prev_flush = 1'b0;
    fifo_word_t prev_data = '0;

    assign bus.fifo_empty = (pushed == popped);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input fifo_word_t word);
        fifo_q.push_back(word);
        exp_q.push_back(word);
        pushed++;
        words_sent++;
    endtask

    task automatic loadRaw(input fifo_word_t word);
        fifo_q.push_back(word);
        pushed++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int limit);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && c < limit) begin
            @(negedge clk);
            c++;
        end
        checkOutput("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Behavioural FIFO read port: one-cycle read latency, registered underflow.
    always @(posedge clk) begin
        fifo_word_t w;
        int n;
        if (!rst_n) begin
            n = fifo_q.size();
            fifo_q.delete();
            popped <= popped + n;
            bus.fifo_underflow <= 1'b0;
            bus.fifo_data_out <= '0;
        end else if (bus.fifo_rd_en) begin
            if (fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                popped <= popped + 1;
                bus.fifo_underflow <= force_uf;
            end else begin
                w = 16'hDEAD;
                bus.fifo_underflow <= 1'b1;
            end
            bus.fifo_data_out <= w;
        end else begin
            bus.fifo_underflow <= 1'b0;
        end
    end

    // Stream monitor: scoreboard compare on each handshake plus the hold rule.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_pop   = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_valid && !prev_pop && !prev_flush) begin
                checkOutput("hold_valid", bus.m_valid, 1);
                checkOutput("hold_data", bus.m_data, prev_data);
            end
            if (dut.occ > 2'd2) occ_bad++;
            if (bus.m_valid && bus.m_ready && !flush) begin
                if (exp_q.size() == 0)
                    checkOutput("unexpected_pop", exp_q.size(), 1);
                else
                    checkOutput("stream_data", bus.m_data, exp_q.pop_front());
            end
            prev_valid = bus.m_valid;
            prev_pop   = bus.m_valid && bus.m_ready;
            prev_flush = flush;
            prev_data  = bus.m_data;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int idle_bad;
        int first_rd, last_rd, rd_n, first_v, last_v, v_n;
        int c, n;

        bus.m_ready = 1'b0;
        enable = 1'b1;
        flush  = 1'b0;
        rst_n  = 1'b0;

        // Reset values
        #2;
        checkOutput("rst_rd_en", bus.fifo_rd_en, 0);
        checkOutput("rst_m_valid", bus.m_valid, 0);
        checkOutput("rst_m_data", bus.m_data, 0);
        checkOutput("rst_xfer_count", xfer_count, 0);
        checkOutput("rst_underflow_err", underflow_err, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with empty FIFO
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.fifo_rd_en || bus.m_valid || xfer_count != 16'd0) idle_bad++;
        end
        checkOutput("idle_quiet", idle_bad, 0);
        step(1);

        // Streaming at full rate
        $display("[TB] streaming 8 words");
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) applyStimulus(16'(i));
        first_rd = -1; last_rd = -1; rd_n = 0;
        first_v = -1; last_v = -1; v_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) begin
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                rd_n++;
            end
            if (bus.m_valid) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                v_n++;
            end
        end
        checkOutput("stream_rd_count", rd_n, 8);
        checkOutput("stream_rd_span", last_rd - first_rd, 7);
        checkOutput("stream_latency", first_v - first_rd, 2);
        checkOutput("stream_valid_count", v_n, 8);
        checkOutput("stream_valid_span", last_v - first_v, 7);
        step(1);
        checkOutput("stream_xfer_count", xfer_count, 16'(words_sent));

        // Backpressure
        $display("[TB] backpressure");
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(16'(i));
        rd_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd_n++;
        end
        checkOutput("bp_rd_count", rd_n, 2);
        checkOutput("bp_occ", dut.occ, 2);
        checkOutput("bp_valid", bus.m_valid, 1);
        checkOutput("bp_head", bus.m_data, 16'h0001);
        step(1);
        bus.m_ready = 1'b1;
        waitDrain(60);
        checkOutput("bp_xfer_count", xfer_count, 16'(words_sent));

        // Random consumer readiness
        $display("[TB] random ready over 200 words");
        for (int i = 0; i < 200; i++) applyStimulus(16'($urandom));
        c = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && c < 3000) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            step(1);
            c++;
        end
        checkOutput("rand_drain", exp_q.size(), 0);
        bus.m_ready = 1'b1;
        step(2);
        checkOutput("rand_occ_bound", occ_bad, 0);
        checkOutput("rand_xfer_count", xfer_count, 16'(words_sent));

        // Flush with one word buffered and one in flight
        $display("[TB] flush");
        bus.m_ready = 1'b0;
        loadRaw(16'h0AA1);
        loadRaw(16'h0BB2);
        applyStimulus(16'h0CC3);
        step(2);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_pre_valid", bus.m_valid, 1);
        checkOutput("flush_pre_head", bus.m_data, 16'h0AA1);
        checkOutput("flush_blocks_rd", bus.fifo_rd_en, 0);
        step(1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid_low", bus.m_valid, 0);
        checkOutput("flush_occ", dut.occ, 0);
        step(1);
        bus.m_ready = 1'b1;
        waitDrain(20);
        checkOutput("flush_xfer_count", xfer_count, 16'(words_sent));

        // Underflowing read is dropped and latched
        $display("[TB] underflow");
        checkOutput("uf_clear_before", underflow_err, 0);
        force_uf = 1'b1;
        loadRaw(16'h00EE);
        step(4);
        force_uf = 1'b0;
        @(negedge clk);
        checkOutput("uf_err_set", underflow_err, 1);
        checkOutput("uf_word_dropped", bus.m_valid, 0);
        step(1);
        applyStimulus(16'h1234);
        waitDrain(20);
        checkOutput("uf_err_sticky", underflow_err, 1);
        checkOutput("uf_xfer_count", xfer_count, 16'(words_sent));

        // Counter wrap
        $display("[TB] counter wrap");
        n = 65535 - words_sent;
        for (int i = 0; i < n; i++) applyStimulus(16'(i));
        waitDrain(n + 100);
        checkOutput("wrap_all_ones", xfer_count, 16'hFFFF);
        applyStimulus(16'hBEEF);
        waitDrain(20);
        checkOutput("wrap_to_zero", xfer_count, 16'h0000);

        // Asynchronous reset mid-stream
        $display("[TB] async reset mid-stream");
        for (int i = 0; i < 6; i++) applyStimulus(16'(16'h0100 + i));
        step(3);
        bus.m_ready = 1'b0;
        step(3);
        checkOutput("pre_reset_valid", bus.m_valid, 1);
        checkOutput("pre_reset_count", (xfer_count != 16'd0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rd_en", bus.fifo_rd_en, 0);
        checkOutput("arst_m_valid", bus.m_valid, 0);
        checkOutput("arst_m_data", bus.m_data, 0);
        checkOutput("arst_xfer_count", xfer_count, 0);
        checkOutput("arst_underflow_err", underflow_err, 0);
        exp_q.delete();
        words_sent = 0;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        checkOutput("post_reset_valid", bus.m_valid, 0);
        bus.m_ready = 1'b1;
        applyStimulus(16'h5A5A);
        waitDrain(20);
        checkOutput("post_reset_xfer_count", xfer_count, 16'(words_sent));
        checkOutput("post_reset_err", underflow_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream drain stage for the synchronous FIFO.
- Issues rd_en into the FIFO read port, absorbs the FIFO's one-cycle read latency, and presents the data as a valid/ready stream to the next consumer.
- Holds a 2-entry output buffer so the stream runs at one word per cycle without combinational ready-to-rd_en paths.
- Also counts completed transfers and flags any read that reaches an empty FIFO.

Parameters:
- FIFO_WIDTH, 16, data width; matches the FIFO data_out width.
- CNT_WIDTH, 16, width of the transfer counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- enable  in  1  permits new FIFO reads. Items already in flight or buffered still drain.
- flush  in  1  synchronous; discards buffered and in-flight data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag; arrives registered, one cycle after rd_en.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after rd_en.
- fifo_rd_en  out  1  FIFO read enable.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready.
- m_data  out  FIFO_WIDTH  stream data (buffer head).
- xfer_count  out  CNT_WIDTH  number of completed stream handshakes; wraps modulo 2^CNT_WIDTH.
- underflow_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n low) clears the buffer (occ=0) and the inflight flag.
  - Outputs: fifo_rd_en=0, m_valid=0, m_data=0, xfer_count=0, underflow_err=0.
  - Reset asserted mid-operation drops all buffered and in-flight data immediately.
- Definitions:
  - pop = m_valid && m_ready.
  - occ = buffer occupancy, 0..2.
  - inflight = registered fifo_rd_en.
- Read issue (combinational): fifo_rd_en = enable && !flush && !fifo_empty && (occ + inflight - pop <= 1).
  - Guarantees occ never exceeds 2.
  - Sustains one read per cycle when m_ready is held high.
- Capture:
  - When inflight=1, fifo_data_out is written into the buffer tail at the next posedge.
  - Exception: if fifo_underflow=1 in that cycle, the word is discarded and underflow_err is set. underflow_err clears only on reset.
- Buffer is 2-entry first-in first-out.
  - m_valid = (occ != 0); m_data = head entry.
  - Capture and pop in the same cycle: occ unchanged, order preserved.
  - Capture with occ=0 and pop=0: new word becomes head.
- Latency: with buffer empty and m_ready=1, rd_en in cycle t gives m_valid=1 in cycle t+2 with that word. Steady-state throughput is 1 word/cycle.
- Stream rule: once m_valid=1, m_data stays stable until pop; m_valid never drops without pop or flush.
- flush=1 (has priority over capture and pop):
  - Next cycle: occ=0, inflight=0, m_valid=0.
  - The word returned for a read issued the cycle before flush is discarded.
  - xfer_count is not incremented for a pop coinciding with flush.
- xfer_count increments by 1 on each pop, wrapping all-ones to 0.
- enable deasserted: no new reads; the in-flight word is still captured; the buffer drains normally.

Decomposition:
- FIFO_shared_pkg gains FIFO_WIDTH default, CNT_WIDTH default, and a typedef for the data word (logic [FIFO_WIDTH-1:0]). The FIFO and this block share it.
- One sub-module, fifo_out_buf: 2-entry register buffer with push, pop, flush and occ output.
- Read-issue logic, inflight flag, counter and error flag stay in the top module.

Test Plan:
- Reset then idle, fifo_empty=1, enable=1 -> fifo_rd_en=0, m_valid=0, xfer_count=0 for 10 cycles. Async rst_n low mid-stream -> outputs zero without waiting for a clock edge.
- FIFO preloaded with 0x0001..0x0008, m_ready=1 -> rd_en on 8 consecutive cycles; m_valid first seen 2 cycles after first rd_en; m_data 0x0001..0x0008 on consecutive cycles; xfer_count=8.
- Backpressure: 8 words loaded, m_ready=0 -> exactly 2 rd_en pulses then fifo_rd_en=0, occ=2, m_data=0x0001 held. Release m_ready -> remaining 6 words in order with no loss or duplication.
- Random m_ready (50%) over 200 words -> output sequence equals input sequence; occ never >2; xfer_count=200.
- flush one cycle after rd_en with occ=1 -> next cycle m_valid=0; the in-flight word never appears on m_data; the following read resumes with the next FIFO word.
- Force fifo_underflow=1 in the capture cycle -> word dropped, underflow_err=1 and stays 1 until rst_n low. xfer_count=0xFFFF plus one pop -> 0x0000.
